bundle_nway_mapper: RTL and testbench

Generalised successor to the two-operand bundle mapper/kernel pair. Bundles a runtime-selected number (1..MAX_OPERANDS) of binary-encoded bipolar hypervectors, word by word, from shared DPRAM into a destination hypervector, using a per-element majority vote and a selectable tie rule. Sits between the kernel mapper (start/done handshake) and the hypervector DPRAM port.

---
 rtl/bundle_pkg.sv | 26 ++
 rtl/bundle_vote_accumulator.sv | 76 +++++++
 rtl/bundle_nway_mapper.sv | 211 +++++++++++++++++++++
 tb/tb_bundle_nway_mapper.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bundle_pkg.sv
// Shared types and constants for the N-way hypervector bundler.
// Contents: FSM state encoding, tie-rule constants, operand-count width helper.
package bundle_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        LAST = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_e;

    localparam logic TIE_FORCE_POS  = 1'b0;
    localparam logic TIE_COPY_FIRST = 1'b1;

    // Width able to hold 0..max_operands, used for op_count and ones counters.
    function automatic int unsigned opc_width(input int unsigned max_operands);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < (max_operands + 32'd1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bundle_vote_accumulator.sv
// Per-element majority vote over a stream of operand words.
// Ports:
//   clk, reset_n  clock, async active-low reset
//   clr           clear all ones counters and the tie register
//   acc_en        add data into the ones counters this cycle
//   first         data is operand 0 of the current word (captured for ties)
//   data          operand word
//   op_count      number of operands being bundled
//   tie_mode      TIE_FORCE_POS or TIE_COPY_FIRST
//   result        vote over the counters including the pending accumulate
module bundle_vote_accumulator
    import bundle_pkg::*;
#(
    parameter int unsigned HV_DATA_WIDTH = 32,
    parameter int unsigned OPC_WIDTH     = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clr,
    input  logic                     acc_en,
    input  logic                     first,
    input  logic [HV_DATA_WIDTH-1:0] data,
    input  logic [OPC_WIDTH-1:0]     op_count,
    input  logic                     tie_mode,
    output logic [HV_DATA_WIDTH-1:0] result
);

    logic [OPC_WIDTH-1:0]     ones_q  [HV_DATA_WIDTH];
    logic [OPC_WIDTH-1:0]     ones_nx [HV_DATA_WIDTH];
    logic [HV_DATA_WIDTH-1:0] tie_q;
    logic [HV_DATA_WIDTH-1:0] tie_nx;

    // Counter values after this cycle's accumulate, so the final operand
    // contributes to the result in the same cycle it arrives.
    always_comb begin
        for (int unsigned e = 0; e < HV_DATA_WIDTH; e++) begin
            ones_nx[e] = ones_q[e] + OPC_WIDTH'(acc_en & data[e]);
        end
        tie_nx = (acc_en && first) ? data : tie_q;
    end

    // Majority compare: 2*ones against op_count, one extra bit of headroom.
    always_comb begin
        result = '0;
        for (int unsigned e = 0; e < HV_DATA_WIDTH; e++) begin
            if ({ones_nx[e], 1'b0} > {1'b0, op_count}) begin
                result[e] = 1'b1;
            end else if ({ones_nx[e], 1'b0} < {1'b0, op_count}) begin
                result[e] = 1'b0;
            end else begin
                result[e] = (tie_mode == TIE_COPY_FIRST) ? tie_nx[e] : 1'b1;
            end
        end
    end

    // Counter and tie storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned e = 0; e < HV_DATA_WIDTH; e++) begin
                ones_q[e] <= '0;
            end
            tie_q <= '0;
        end else if (clr) begin
            for (int unsigned e = 0; e < HV_DATA_WIDTH; e++) begin
                ones_q[e] <= '0;
            end
            tie_q <= '0;
        end else if (acc_en) begin
            for (int unsigned e = 0; e < HV_DATA_WIDTH; e++) begin
                ones_q[e] <= ones_nx[e];
            end
            tie_q <= tie_nx;
        end
    end

endmodule

// File: rtl/bundle_nway_mapper.sv
// Bundles 1..MAX_OPERANDS hypervectors from DPRAM into a destination vector,
// one word at a time, using a per-element majority vote.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   start                 request pulse, sampled only in IDLE
//   op_base, op_stride    operand 0 address and distance between operands
//   op_count, hv_words    operand count and vector length in words
//   dst_base, tie_mode    destination address and tie rule
//   we_n, address,        DPRAM port (registered outputs)
//   data_wr, data_rd      read data arrives one cycle after its address
//   busy, done, err       status; err accompanies done on a rejected request
module bundle_nway_mapper
    import bundle_pkg::*;
#(
    parameter  int unsigned HV_DATA_WIDTH    = 32,
    parameter  int unsigned HV_ADDRESS_WIDTH = 20,
    parameter  int unsigned MAX_OPERANDS     = 8,
    localparam int unsigned OPC_WIDTH        = opc_width(MAX_OPERANDS)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [HV_ADDRESS_WIDTH-1:0] op_base,
    input  logic [HV_ADDRESS_WIDTH-1:0] op_stride,
    input  logic [OPC_WIDTH-1:0]        op_count,
    input  logic [HV_ADDRESS_WIDTH-1:0] hv_words,
    input  logic [HV_ADDRESS_WIDTH-1:0] dst_base,
    input  logic                        tie_mode,
    output logic                        we_n,
    output logic [HV_ADDRESS_WIDTH-1:0] address,
    output logic [HV_DATA_WIDTH-1:0]    data_wr,
    input  logic [HV_DATA_WIDTH-1:0]    data_rd,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int unsigned AW = HV_ADDRESS_WIDTH;

    state_e               state_q, state_nx;
    logic [OPC_WIDTH-1:0] k_q, k_nx;
    logic [AW-1:0]        w_q, w_nx;
    logic [AW-1:0]        row_q, row_nx;     // op_base + w
    logic [AW-1:0]        rd_q, rd_nx;       // op_base + k*op_stride + w
    logic [AW-1:0]        wp_q, wp_nx;       // dst_base + w
    logic [AW-1:0]        stride_q;
    logic [AW-1:0]        words_q;
    logic [OPC_WIDTH-1:0] count_q;
    logic                 tie_mode_q;
    logic                 reject_c;

    logic                     we_n_nx, busy_nx, done_nx, err_nx;
    logic [AW-1:0]            address_nx;
    logic [HV_DATA_WIDTH-1:0] data_wr_nx;

    logic                     acc_en_c, first_c, clr_c;
    logic [HV_DATA_WIDTH-1:0] vote_c;

    // Accumulate the read issued last cycle; operand 0 arrives at k==1,
    // or in LAST when only one operand is bundled.
    assign acc_en_c = ((state_q == RD) && (k_q != '0)) || (state_q == LAST);
    assign first_c  = ((state_q == RD) && (k_q == OPC_WIDTH'(1)))
                   || ((state_q == LAST) && (count_q == OPC_WIDTH'(1)));
    assign clr_c    = (state_q == WR);

    bundle_vote_accumulator #(
        .HV_DATA_WIDTH (HV_DATA_WIDTH),
        .OPC_WIDTH     (OPC_WIDTH)
    ) u_vote (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (clr_c),
        .acc_en   (acc_en_c),
        .first    (first_c),
        .data     (data_rd),
        .op_count (count_q),
        .tie_mode (tie_mode_q),
        .result   (vote_c)
    );

    // Next state and address pointers.
    always_comb begin
        state_nx = state_q;
        k_nx     = k_q;
        w_nx     = w_q;
        row_nx   = row_q;
        rd_nx    = rd_q;
        wp_nx    = wp_q;
        reject_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if ((op_count == '0) || (op_count > OPC_WIDTH'(MAX_OPERANDS))
                        || (hv_words == '0)) begin
                        reject_c = 1'b1;
                        state_nx = DONE;
                    end else begin
                        state_nx = RD;
                        k_nx     = '0;
                        w_nx     = '0;
                        row_nx   = op_base;
                        rd_nx    = op_base;
                        wp_nx    = dst_base;
                    end
                end
            end
            RD: begin
                if (k_q == (count_q - OPC_WIDTH'(1))) begin
                    state_nx = LAST;
                end else begin
                    k_nx  = k_q + OPC_WIDTH'(1);
                    rd_nx = rd_q + stride_q;
                end
            end
            LAST: begin
                state_nx = WR;
            end
            WR: begin
                if (w_q == (words_q - AW'(1))) begin
                    state_nx = DONE;
                end else begin
                    state_nx = RD;
                    k_nx     = '0;
                    w_nx     = w_q + AW'(1);
                    row_nx   = row_q + AW'(1);
                    rd_nx    = row_q + AW'(1);
                    wp_nx    = wp_q + AW'(1);
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state.
    always_comb begin
        we_n_nx    = 1'b1;
        address_nx = '0;
        data_wr_nx = '0;
        busy_nx    = 1'b0;
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        unique case (state_nx)
            RD: begin
                busy_nx    = 1'b1;
                address_nx = rd_nx;
            end
            LAST: begin
                busy_nx = 1'b1;
            end
            WR: begin
                busy_nx    = 1'b1;
                we_n_nx    = 1'b0;
                address_nx = wp_nx;
                data_wr_nx = vote_c;
            end
            DONE: begin
                done_nx = 1'b1;
                err_nx  = reject_c;
            end
            default: begin
            end
        endcase
    end

    // State, pointers, latched request and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            k_q        <= '0;
            w_q        <= '0;
            row_q      <= '0;
            rd_q       <= '0;
            wp_q       <= '0;
            stride_q   <= '0;
            words_q    <= '0;
            count_q    <= '0;
            tie_mode_q <= 1'b0;
            we_n       <= 1'b1;
            address    <= '0;
            data_wr    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q <= state_nx;
            k_q     <= k_nx;
            w_q     <= w_nx;
            row_q   <= row_nx;
            rd_q    <= rd_nx;
            wp_q    <= wp_nx;
            if ((state_q == IDLE) && start) begin
                stride_q   <= op_stride;
                words_q    <= hv_words;
                count_q    <= op_count;
                tie_mode_q <= tie_mode;
            end
            we_n    <= we_n_nx;
            address <= address_nx;
            data_wr <= data_wr_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            err     <= err_nx;
        end
    end

endmodule

// File: tb/tb_bundle_nway_mapper.sv
// Directed bench for bundle_nway_mapper with a DPRAM model and a write scoreboard.
module tb_bundle_nway_mapper;

    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 20;
    localparam int unsigned MAXOP = 8;
    localparam int unsigned OPCW = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic [AW-1:0]   op_base, op_stride, hv_words, dst_base;
    logic [OPCW-1:0] op_count;
    logic            tie_mode;
    logic            we_n;
    logic [AW-1:0]   address;
    logic [DW-1:0]   data_wr;
    logic [DW-1:0]   data_rd;
    logic            busy, done, err;

    always #5 clk = ~clk;

    bundle_nway_mapper #(
        .HV_DATA_WIDTH    (DW),
        .HV_ADDRESS_WIDTH (AW),
        .MAX_OPERANDS     (MAXOP)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .op_base   (op_base),
        .op_stride (op_stride),
        .op_count  (op_count),
        .hv_words  (hv_words),
        .dst_base  (dst_base),
        .tie_mode  (tie_mode),
        .we_n      (we_n),
        .address   (address),
        .data_wr   (data_wr),
        .data_rd   (data_rd),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // DPRAM read side: data follows the address by one cycle.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) data_rd <= mem[address];

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] a;
    } obs_t;

    wr_t  exp_q [$];
    obs_t trace_q [$];
    wr_t  mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every DPRAM write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && we_n === 1'b0) begin
            check("write_expected", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("write_addr", 32'(address), 32'(mon_e.a));
                check("write_data", 32'(data_wr), 32'(mon_e.d));
            end
        end
    end

    // Reference bundle: direct k*stride addressing and per-bit counting.
    task automatic push_model(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                              input int cnt, input int words, input logic [AW-1:0] dst,
                              input logic tie);
        for (int w = 0; w < words; w++) begin
            logic [DW-1:0] res;
            logic [DW-1:0] wd;
            logic [DW-1:0] first;
            first = mem[base + AW'(w)];
            for (int e = 0; e < int'(DW); e++) begin
                int ones;
                ones = 0;
                for (int k = 0; k < cnt; k++) begin
                    wd = mem[base + AW'(k) * stride + AW'(w)];
                    ones += int'(wd[e]);
                end
                if (2 * ones > cnt)      res[e] = 1'b1;
                else if (2 * ones < cnt) res[e] = 1'b0;
                else                     res[e] = tie ? first[e] : 1'b1;
            end
            exp_q.push_back('{a: dst + AW'(w), d: res});
        end
    endtask

    task automatic push_lit(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back('{a: a, d: d});
    endtask

    // Issue one request, scramble the inputs, and time done against exp_done.
    task automatic run_op(input string tag, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                          input int cnt, input logic [AW-1:0] words, input logic [AW-1:0] dst,
                          input logic tie, input int exp_done, input logic exp_err, input int poke);
        int n;
        bit got;
        int busy_bad;
        trace_q.delete();
        op_base   = base;
        op_stride = stride;
        op_count  = OPCW'(cnt);
        hv_words  = words;
        dst_base  = dst;
        tie_mode  = tie;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        op_base   = '1;
        op_stride = '1;
        op_count  = '1;
        hv_words  = '1;
        dst_base  = '1;
        tie_mode  = ~tie;
        n = 0;
        got = 1'b0;
        busy_bad = 0;
        while (!got && n < 400) begin
            @(negedge clk);
            n++;
            start = (n == poke);
            trace_q.push_back('{we: we_n, a: address});
            if (done === 1'b1) got = 1'b1;
            else if (busy !== 1'b1) busy_bad++;
        end
        check({tag, "_done_seen"}, 32'(got), 32'(1));
        check({tag, "_done_cycle"}, 32'(n), 32'(exp_done));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_busy_at_done"}, 32'(busy), 32'(0));
        check({tag, "_busy_gaps"}, 32'(busy_bad), 32'(0));
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done_pulse"}, 32'(done), 32'(0));
        check({tag, "_err_clear"}, 32'(err), 32'(0));
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        op_base   = '0;
        op_stride = '0;
        op_count  = '0;
        hv_words  = '0;
        dst_base  = '0;
        tie_mode  = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_we_n", 32'(we_n), 32'(1));
        check("rst_address", 32'(address), 32'(0));
        check("rst_data_wr", 32'(data_wr), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        reset_n = 1'b1;
        @(negedge clk);

        // Majority of three
        mem[20'h0] = 8'hF0;
        mem[20'h1] = 8'hCC;
        mem[20'h2] = 8'hAA;
        push_lit(20'h100, 8'hE8);
        run_op("majority", 20'h0, 20'h1, 3, 20'h1, 20'h100, 1'b0, 6, 1'b0, -1);

        // Two-operand ties under both rules
        mem[20'h200] = 8'hF0;
        mem[20'h201] = 8'h0F;
        push_lit(20'h101, 8'hFF);
        run_op("tie_pos", 20'h200, 20'h1, 2, 20'h1, 20'h101, 1'b0, 5, 1'b0, -1);
        push_lit(20'h101, 8'hF0);
        run_op("tie_first", 20'h200, 20'h1, 2, 20'h1, 20'h101, 1'b1, 5, 1'b0, -1);

        // Strided multi-word bundle, start poked while busy
        for (int k = 0; k < 3; k++)
            for (int w = 0; w < 4; w++)
                mem[20'h10 + AW'(k) * 20'h20 + AW'(w)] = DW'($urandom);
        push_model(20'h10, 20'h20, 3, 4, 20'h300, 1'b0);
        run_op("stride", 20'h10, 20'h20, 3, 20'h4, 20'h300, 1'b0, 21, 1'b0, 3);
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("rd_addr_w%0d_k%0d", w, k),
                      32'(trace_q[w * 5 + k].a), 32'(20'h10 + AW'(k) * 20'h20 + AW'(w)));
                check($sformatf("rd_we_w%0d_k%0d", w, k), 32'(trace_q[w * 5 + k].we), 32'(1));
            end
            check($sformatf("last_addr_w%0d", w), 32'(trace_q[w * 5 + 3].a), 32'(0));
        end

        // Maximum operand count with tie copy
        for (int k = 0; k < int'(MAXOP); k++) mem[20'h600 + AW'(k)] = DW'($urandom);
        push_model(20'h600, 20'h1, int'(MAXOP), 1, 20'h700, 1'b1);
        run_op("max_ops", 20'h600, 20'h1, int'(MAXOP), 20'h1, 20'h700, 1'b1, 11, 1'b0, -1);

        // Rejections: no access, done and err together one cycle after start
        run_op("rej_cnt0", 20'h77, 20'h1, 0, 20'h1, 20'h800, 1'b0, 1, 1'b1, -1);
        check("rej_cnt0_addr", 32'(trace_q[0].a), 32'(0));
        check("rej_cnt0_we", 32'(trace_q[0].we), 32'(1));
        run_op("rej_cnt9", 20'h77, 20'h1, int'(MAXOP) + 1, 20'h1, 20'h800, 1'b0, 1, 1'b1, -1);
        check("rej_cnt9_addr", 32'(trace_q[0].a), 32'(0));
        run_op("rej_words0", 20'h77, 20'h1, 2, 20'h0, 20'h800, 1'b0, 1, 1'b1, -1);
        check("rej_words0_addr", 32'(trace_q[0].a), 32'(0));

        // Destination wraps past the top of the address space
        mem[20'h400] = DW'($urandom);
        mem[20'h401] = DW'($urandom);
        push_lit(20'hFFFFF, mem[20'h400]);
        push_lit(20'h00000, mem[20'h401]);
        run_op("wrap", 20'h400, 20'h1, 1, 20'h2, 20'hFFFFF, 1'b0, 7, 1'b0, -1);

        // Reset during the second word's reads
        push_model(20'h10, 20'h20, 3, 1, 20'h500, 1'b0);
        op_base   = 20'h10;
        op_stride = 20'h20;
        op_count  = 4'd3;
        hv_words  = 20'h4;
        dst_base  = 20'h500;
        tie_mode  = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_busy_before", 32'(busy), 32'(1));
        check("mid_addr_before", 32'(address), 32'(20'h31));
        reset_n = 1'b0;
        #1;
        check("mid_we_n", 32'(we_n), 32'(1));
        check("mid_busy", 32'(busy), 32'(0));
        check("mid_done", 32'(done), 32'(0));
        check("mid_address", 32'(address), 32'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_done_after", 32'(done), 32'(0));
        check("mid_busy_after", 32'(busy), 32'(0));
        check("mid_queue", 32'(exp_q.size()), 32'(0));

        push_lit(20'h102, 8'hE8);
        run_op("post_reset", 20'h0, 20'h1, 3, 20'h1, 20'h102, 1'b0, 6, 1'b0, -1);

        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
